// File: rtl/dlbf_data_pkg.sv
// Shared types and constants for the dlbf data player: FSM states, CSR bit map, default widths.
package dlbf_data_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int CSR_BUSY   = 31;
    localparam int CSR_DONE   = 30;
    localparam int CSR_ERR    = 29;
    localparam int DEF_ADDR_W = 16;
    localparam int DEF_DATA_W = 64;

endpackage

// File: rtl/dlbf_data_player_if.sv
// AXI4-Stream bundle carrying played-out samples toward the AIE array.
interface dlbf_data_player_if #(
    parameter int DATA_W = 64
);
    logic [DATA_W-1:0] tdata;
    logic              tvalid;
    logic              tready;
    logic              tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/dlbf_data_fifo.sv
// Flop-based FWFT FIFO with occupancy count; rd_vld one cycle after the push edge.
// Writer must respect count; a push into a full FIFO is accepted only alongside a pop.
module dlbf_data_fifo #(
    parameter int W     = 65,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_vld,
    input  logic [W-1:0]             wr_dat,
    output logic                     rd_vld,
    input  logic                     rd_rdy,
    output logic [W-1:0]             rd_dat,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          push, pop;

    always_comb begin
        pop      = (count_q != '0) && rd_rdy;
        push     = wr_vld && ((count_q != (AW+1)'(DEPTH)) || pop);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = wr_dat;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign rd_vld = (count_q != '0);
    assign rd_dat = mem_q[rd_ptr_q];
    assign count  = count_q;

endmodule

// File: rtl/dlbf_data_player.sv
// Plays a BRAM window out as AXI4-Stream, optionally repeated; tvalid appears RD_LAT+2 cycles after start.
// Reads are credit-limited against FIFO space, so tready backpressure simply throttles enb.
module dlbf_data_player
    import dlbf_data_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int RD_LAT     = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  BRAM_PORTB_clk,
    input  logic                  BRAM_PORTB_rst,
    input  logic                  ctrl_start,
    input  logic                  ctrl_stop,
    input  logic [ADDR_W-1:0]     cfg_base_addr,
    input  logic [15:0]           cfg_length,
    input  logic [15:0]           cfg_repeat,
    output logic [ADDR_W-1:0]     addrb,
    output logic                  enb,
    input  logic [DATA_W-1:0]     doutb,
    dlbf_data_player_if.master    m_axis,
    output logic [31:0]           csr_rddata
);
    localparam int CNT_W = $clog2(FIFO_DEPTH + RD_LAT + 1) + 1;
    localparam int FC_W  = $clog2(FIFO_DEPTH) + 1;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [15:0]         len_q, len_d, rep_q, rep_d;
    logic [15:0]         offset_q, offset_d, iter_q, iter_d;
    logic                done_q, done_d, err_q, err_d;
    logic [RD_LAT-1:0]   sr_vld_q, sr_vld_d, sr_last_q, sr_last_d;
    logic [FC_W-1:0]     fifo_count;
    logic [CNT_W-1:0]    in_flight, occupancy;
    logic                credit_ok, issue_last, fifo_rd_vld;
    logic [DATA_W:0]     fifo_rd_dat;

    // Outstanding words = reads still in the BRAM pipe plus words parked in the FIFO.
    always_comb begin
        in_flight = '0;
        for (int i = 0; i < RD_LAT; i++) in_flight = in_flight + CNT_W'(sr_vld_q[i]);
        occupancy = in_flight + CNT_W'(fifo_count);
        credit_ok = occupancy < CNT_W'(FIFO_DEPTH);
    end

    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        len_d      = len_q;
        rep_d      = rep_q;
        offset_d   = offset_q;
        iter_d     = iter_q;
        done_d     = done_q;
        err_d      = err_q;
        enb        = 1'b0;
        issue_last = (offset_q == len_q - 16'd1);
        unique case (state_q)
            IDLE: begin
                if (ctrl_start) begin
                    if (cfg_length != '0) begin
                        base_d   = cfg_base_addr;
                        len_d    = cfg_length;
                        rep_d    = cfg_repeat;
                        offset_d = '0;
                        iter_d   = '0;
                        done_d   = 1'b0;
                        err_d    = 1'b0;
                        state_d  = RUN;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (ctrl_stop) begin
                    state_d = DRAIN;
                end else if (credit_ok) begin
                    enb = 1'b1;
                    if (issue_last) begin
                        offset_d = '0;
                        iter_d   = iter_q + 16'd1;
                        if ((rep_q != '0) && (iter_d == rep_q)) state_d = DRAIN;
                    end else begin
                        offset_d = offset_q + 16'd1;
                    end
                end
            end
            DRAIN: begin
                if ((in_flight == '0) && (fifo_count == '0)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Valid/last travel beside each read so the FIFO push lines up with doutb.
    always_comb begin
        sr_vld_d  = (sr_vld_q << 1) | RD_LAT'(enb);
        sr_last_d = (sr_last_q << 1) | RD_LAT'(enb && issue_last);
    end

    always_ff @(posedge BRAM_PORTB_clk or posedge BRAM_PORTB_rst) begin
        if (BRAM_PORTB_rst) begin
            state_q   <= IDLE;
            base_q    <= '0;
            len_q     <= '0;
            rep_q     <= '0;
            offset_q  <= '0;
            iter_q    <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            sr_vld_q  <= '0;
            sr_last_q <= '0;
        end else begin
            state_q   <= state_d;
            base_q    <= base_d;
            len_q     <= len_d;
            rep_q     <= rep_d;
            offset_q  <= offset_d;
            iter_q    <= iter_d;
            done_q    <= done_d;
            err_q     <= err_d;
            sr_vld_q  <= sr_vld_d;
            sr_last_q <= sr_last_d;
        end
    end

    assign addrb = base_q + ADDR_W'(offset_q);

    dlbf_data_fifo #(
        .W     (DATA_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (BRAM_PORTB_clk),
        .rst    (BRAM_PORTB_rst),
        .wr_vld (sr_vld_q[RD_LAT-1]),
        .wr_dat ({sr_last_q[RD_LAT-1], doutb}),
        .rd_vld (fifo_rd_vld),
        .rd_rdy (m_axis.tready),
        .rd_dat (fifo_rd_dat),
        .count  (fifo_count)
    );

    assign m_axis.tvalid = fifo_rd_vld;
    assign m_axis.tdata  = fifo_rd_dat[DATA_W-1:0];
    assign m_axis.tlast  = fifo_rd_dat[DATA_W];

    always_comb begin
        csr_rddata           = '0;
        csr_rddata[CSR_BUSY] = (state_q != IDLE);
        csr_rddata[CSR_DONE] = done_q;
        csr_rddata[CSR_ERR]  = err_q;
        csr_rddata[15:0]     = iter_q;
    end

endmodule

// File: tb/tb_dlbf_data_player.sv
// Bench for dlbf_data_player: BRAM model returns word n = n; scoreboard queues hold expected addresses and beats.
module tb_dlbf_data_player;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ctrl_start = 1'b0, ctrl_stop = 1'b0;
    logic [15:0] cfg_base_addr = '0, cfg_length = '0, cfg_repeat = '0;
    logic [15:0] addrb;
    logic        enb;
    logic [63:0] doutb = '0;
    logic [31:0] csr_rddata;
    logic        bp_mode = 1'b0;

    dlbf_data_player_if #(.DATA_W(64)) m_axis();

    dlbf_data_player dut (
        .BRAM_PORTB_clk (clk),
        .BRAM_PORTB_rst (rst),
        .ctrl_start     (ctrl_start),
        .ctrl_stop      (ctrl_stop),
        .cfg_base_addr  (cfg_base_addr),
        .cfg_length     (cfg_length),
        .cfg_repeat     (cfg_repeat),
        .addrb          (addrb),
        .enb            (enb),
        .doutb          (doutb),
        .m_axis         (m_axis.master),
        .csr_rddata     (csr_rddata)
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [64:0] act;
        logic [64:0] exp;
    } chk_t;

    chk_t        chk_q[$];
    logic [64:0] exp_d[$];
    logic [15:0] exp_a[$];
    int          d_idx = 0, a_idx = 0, c_idx = 0;
    int          total = 0, bad = 0;
    int          outstanding = 0;
    logic        stall_prev = 1'b0;
    logic [64:0] held = '0;

    // Two-cycle BRAM: address captured mid-cycle, data appears the cycle after next.
    initial begin : bram_model
        logic        s_en;
        logic [15:0] s_a, a1;
        a1 = '0;
        forever begin
            @(negedge clk);
            s_en = enb;
            s_a  = addrb;
            @(posedge clk);
            #1;
            doutb = 64'(a1);
            if (s_en) a1 = s_a;
        end
    end

    initial begin : ready_driver
        m_axis.tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            m_axis.tready = bp_mode ? !m_axis.tready : 1'b1;
        end
    end

    task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin : monitor
        logic xfer;
        if (rst) begin
            d_idx       = exp_d.size();
            a_idx       = exp_a.size();
            outstanding = 0;
            stall_prev  = 1'b0;
        end else begin
            xfer = m_axis.tvalid && m_axis.tready;
            if (enb) begin
                if (a_idx < exp_a.size()) begin
                    check("addrb", 65'(addrb), 65'(exp_a[a_idx]));
                    a_idx++;
                end else begin
                    check("unexpected_enb", 65'(1), 65'(0));
                end
                check("credit", 65'(outstanding < DEPTH), 65'(1));
            end
            if (stall_prev) begin
                check("hold_tvalid", 65'(m_axis.tvalid), 65'(1));
                check("hold_data", {m_axis.tlast, m_axis.tdata}, held);
            end
            if (xfer) begin
                if (d_idx < exp_d.size()) begin
                    check("beat", {m_axis.tlast, m_axis.tdata}, exp_d[d_idx]);
                    d_idx++;
                end else begin
                    check("extra_beat", 65'(1), 65'(0));
                end
            end
            stall_prev  = m_axis.tvalid && !m_axis.tready;
            held        = {m_axis.tlast, m_axis.tdata};
            outstanding = outstanding + (enb ? 1 : 0) - (xfer ? 1 : 0);
        end
        while (c_idx < chk_q.size()) begin
            check(chk_q[c_idx].name, chk_q[c_idx].act, chk_q[c_idx].exp);
            c_idx++;
        end
    end

    task automatic req(input string name, input logic [64:0] act, input logic [64:0] exp);
        chk_t c;
        c.name = name;
        c.act  = act;
        c.exp  = exp;
        chk_q.push_back(c);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic plan(input logic [15:0] base, input int len, input int n);
        for (int k = 0; k < n; k++) begin
            logic [15:0] a;
            a = base + 16'(k % len);
            exp_a.push_back(a);
            exp_d.push_back({(k % len) == len - 1, 48'h0, a});
        end
    endtask

    task automatic start_pulse();
        ctrl_start = 1'b1;
        cyc();
        ctrl_start = 1'b0;
    endtask

    task automatic wait_drained(input string name, input int limit);
        int n = 0;
        while ((d_idx != exp_d.size() || a_idx != exp_a.size()) && n < limit) begin
            cyc();
            n++;
        end
        req(name, 65'(n < limit), 65'(1));
    endtask

    initial begin : stimulus
        int cnt;
        repeat (2) cyc();
        req("rst_tvalid", 65'(m_axis.tvalid), 65'(0));
        req("rst_tlast_tdata", {m_axis.tlast, m_axis.tdata}, 65'(0));
        req("rst_enb_addrb", {enb, addrb}, 65'(0));
        req("rst_csr", 65'(csr_rddata), 65'(0));
        rst = 1'b0;
        cyc();

        // basic single pass
        cfg_base_addr = 16'h0010; cfg_length = 16'd4; cfg_repeat = 16'd1;
        plan(16'h0010, 4, 4);
        start_pulse();
        req("first_enb_cycle1", 65'(enb), 65'(1));
        repeat (2) cyc();
        req("tvalid_cycle3", 65'(m_axis.tvalid), 65'(0));
        cyc();
        req("tvalid_cycle4", 65'(m_axis.tvalid), 65'(1));
        wait_drained("basic_drain", 100);
        repeat (2) cyc();
        req("basic_csr", 65'(csr_rddata), 65'(32'h4000_0001));

        // backpressure
        cfg_base_addr = 16'h0020; cfg_length = 16'd8; cfg_repeat = 16'd1;
        plan(16'h0020, 8, 8);
        bp_mode = 1'b1;
        start_pulse();
        wait_drained("bp_drain", 200);
        bp_mode = 1'b0;
        repeat (2) cyc();
        req("bp_csr", 65'(csr_rddata), 65'(32'h4000_0001));

        // address wrap with three iterations back to back
        cfg_base_addr = 16'hFFFE; cfg_length = 16'd4; cfg_repeat = 16'd3;
        plan(16'hFFFE, 4, 12);
        start_pulse();
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            cnt += enb ? 1 : 0;
            cyc();
        end
        req("wrap_no_gap", 65'(cnt), 65'(12));
        req("wrap_enb_off", 65'(enb), 65'(0));
        wait_drained("wrap_drain", 200);
        repeat (2) cyc();
        req("wrap_csr", 65'(csr_rddata), 65'(32'h4000_0003));

        // infinite repeat, stop in cycle 20 -> reads in cycles 1..19
        cfg_base_addr = 16'h0100; cfg_length = 16'd5; cfg_repeat = 16'd0;
        plan(16'h0100, 5, 19);
        start_pulse();
        repeat (19) cyc();
        ctrl_stop = 1'b1;
        cyc();
        ctrl_stop = 1'b0;
        wait_drained("stop_drain", 200);
        repeat (4) cyc();
        req("stop_csr", 65'(csr_rddata), 65'(32'h4000_0003));

        // zero length start: err set, done and iter_count untouched
        cfg_length = 16'd0;
        start_pulse();
        req("illegal_csr", 65'(csr_rddata), 65'(32'h6000_0003));
        repeat (3) cyc();
        req("illegal_no_enb", 65'(enb), 65'(0));

        // second start while busy is ignored
        cfg_base_addr = 16'h0040; cfg_length = 16'd6; cfg_repeat = 16'd1;
        plan(16'h0040, 6, 6);
        start_pulse();
        cyc();
        cfg_base_addr = 16'h0080; cfg_length = 16'd2; cfg_repeat = 16'd5;
        start_pulse();
        wait_drained("overlap_drain", 200);
        repeat (2) cyc();
        req("overlap_csr", 65'(csr_rddata), 65'(32'h4000_0001));

        // asynchronous reset mid-run, then a clean restart
        cfg_base_addr = 16'h0200; cfg_length = 16'd16; cfg_repeat = 16'd0;
        plan(16'h0200, 16, 16);
        start_pulse();
        repeat (8) cyc();
        rst = 1'b1;
        #1;
        req("arst_tvalid_tlast", {m_axis.tvalid, m_axis.tlast}, 65'(0));
        req("arst_enb_addrb", {enb, addrb}, 65'(0));
        req("arst_csr", 65'(csr_rddata), 65'(0));
        repeat (2) cyc();
        rst = 1'b0;
        cyc();
        cfg_length = 16'd3; cfg_repeat = 16'd1;
        plan(16'h0200, 3, 3);
        start_pulse();
        wait_drained("restart_drain", 100);
        repeat (2) cyc();
        req("restart_csr", 65'(csr_rddata), 65'(32'h4000_0001));

        repeat (3) cyc();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
